bcd_tick_counter: RTL



---
 rtl/bcd_tick_counter_pkg.sv | 16 +
 rtl/bcd_tick_counter_if.sv | 29 ++
 rtl/bcd_tick_counter_digit.sv | 46 ++++
 rtl/bcd_tick_counter.sv | 95 +++++++++
 4 files changed

// File: rtl/bcd_tick_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_tick_counter_pkg
// Brief    : Shared digit type and limits for the BCD tick counter.
// Revision : 1.0  initial release
// ============================================================================
package bcd_tick_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam bcd_digit_t BCD_MIN    = 4'd0;
    localparam int         MAX_DIGITS = 4;

endpackage
`default_nettype wire

// File: rtl/bcd_tick_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_tick_counter_if
// Brief    : Control and count bus between the rate divider and the counter.
// Revision : 1.0  initial release
// ============================================================================
interface bcd_tick_counter_if #(
    parameter int DIGITS = 2
);
    logic                  tick;
    logic                  run;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   bcd;
    logic                  wrap;
    logic                  zero;

    modport master (
        output tick, run, up, load, load_value,
        input  bcd, wrap, zero
    );

    modport slave (
        input  tick, run, up, load, load_value,
        output bcd, wrap, zero
    );
endinterface
`default_nettype wire

// File: rtl/bcd_tick_counter_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Brief    : One registered BCD digit with clamped load and ripple carry/borrow.
// Revision : 1.0  initial release
// ============================================================================
module bcd_digit
    import bcd_tick_counter_pkg::*;
(
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic en,
    input  wire logic up,
    input  wire logic load,
    input  bcd_digit_t load_nibble,
    output bcd_digit_t value,
    output bcd_digit_t next_value,
    output logic       carry,
    output logic       borrow
);

    always_comb begin
        next_value = value;
        if (load) begin
            next_value = (load_nibble > BCD_MAX) ? BCD_MAX : load_nibble;
        end else if (en) begin
            if (up)
                next_value = (value == BCD_MAX) ? BCD_MIN : value + 4'd1;
            else
                next_value = (value == BCD_MIN) ? BCD_MAX : value - 4'd1;
        end
    end

    // Combinational so a full chain of 9s/0s ripples within one cycle.
    assign carry  = en &  up & (value == BCD_MAX);
    assign borrow = en & ~up & (value == BCD_MIN);

    always_ff @(posedge clock) begin
        if (reset)
            value <= BCD_MIN;
        else
            value <= next_value;
    end

endmodule
`default_nettype wire

// File: rtl/bcd_tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_tick_counter
// Brief    : DIGITS-wide BCD up/down counter with load, run/hold and wrap pulse.
//            Define BCD_TICK_COUNTER_SATURATE_EN to saturate instead of rolling.
// Revision : 1.0  initial release
// ============================================================================
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  wire logic          clock,
    input  wire logic          reset,
    bcd_tick_counter_if.slave  bus
);

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_tick_counter: DIGITS must be in 1..%0d", MAX_DIGITS);
    end

    logic [DIGITS-1:0]   en;
    logic [DIGITS-1:0]   carry;
    logic [DIGITS-1:0]   borrow;
    logic [4*DIGITS-1:0] value_vec;
    logic [4*DIGITS-1:0] next_vec;
    logic                count_req;
    logic                step;
    logic                wrap_next;
    logic                wrap_q;
    logic                zero_q;

    // A tick coinciding with load is dropped.
    assign count_req = bus.tick & bus.run & ~bus.load;

`ifdef BCD_TICK_COUNTER_SATURATE_EN
    logic at_max;
    logic at_min;
    logic limit;

    always_comb begin
        at_max = 1'b1;
        at_min = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (value_vec[4*i +: 4] != BCD_MAX) at_max = 1'b0;
            if (value_vec[4*i +: 4] != BCD_MIN) at_min = 1'b0;
        end
    end

    // At the limit the step is suppressed but wrap still flags "limit hit".
    assign limit     = bus.up ? at_max : at_min;
    assign step      = count_req & ~limit;
    assign wrap_next = count_req & limit;
`else
    assign step      = count_req;
    assign wrap_next = carry[DIGITS-1] | borrow[DIGITS-1];
`endif

    assign en[0] = step;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i > 0) begin : g_chain
            assign en[i] = carry[i-1] | borrow[i-1];
        end

        bcd_digit u_digit (
            .clock       (clock),
            .reset       (reset),
            .en          (en[i]),
            .up          (bus.up),
            .load        (bus.load),
            .load_nibble (bus.load_value[4*i +: 4]),
            .value       (value_vec[4*i +: 4]),
            .next_value  (next_vec[4*i +: 4]),
            .carry       (carry[i]),
            .borrow      (borrow[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrap_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            wrap_q <= wrap_next;
            zero_q <= (next_vec == '0);
        end
    end

    assign bus.bcd  = value_vec;
    assign bus.wrap = wrap_q;
    assign bus.zero = zero_q;

endmodule
`default_nettype wire
